// File: rtl/rrv_hazard_ctrl.sv
// Pipeline hazard control for the 5-stage RV32I core: scoreboard, EX forwarding selects, load-use stall, jump flush.
// Optional performance counters are built when RRV_HAZARD_PERF_EN is defined.
module rrv_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_DEPTH    = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic                      id_rs1_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                      id_rd_we,
  input  logic                      id_is_load,
  input  logic                      jump_en,
  output logic                      pc_en,
  output logic                      ifid_en,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic [1:0]                fwd_rs1_sel,
  output logic [1:0]                fwd_rs2_sel,
  output logic [1:0]                ctrl_state,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam int FCW = $clog2(FLUSH_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic                      vld;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      we;
    logic                      load;
  } sb_entry_t;

  state_e             state_q, state_d;
  logic [FCW-1:0]     fcnt_q, fcnt_d;
  sb_entry_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0]         fwd_rs1_q, fwd_rs1_d, fwd_rs2_q, fwd_rs2_d;

  logic id_live;
  logic rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit;
  logic load_use;
  logic stall;
  logic ex_take_id;
  logic wb_unused;

  function automatic logic src_hit(input logic used,
                                   input logic [REG_ADDR_WIDTH-1:0] addr,
                                   input sb_entry_t e);
    return used && e.vld && e.we && (addr == e.rd) && (addr != '0);
  endfunction

  // The ID slot carries only wrong-path bubbles while flushing, so it never matches.
  always_comb begin
    id_live     = id_valid && (state_q != ST_FLUSH);
    rs1_ex_hit  = id_live && src_hit(id_rs1_used, id_rs1_addr, ex_q);
    rs2_ex_hit  = id_live && src_hit(id_rs2_used, id_rs2_addr, ex_q);
    rs1_mem_hit = id_live && src_hit(id_rs1_used, id_rs1_addr, mem_q);
    rs2_mem_hit = id_live && src_hit(id_rs2_used, id_rs2_addr, mem_q);
    load_use    = ex_q.load && (rs1_ex_hit || rs2_ex_hit);
    stall       = !rst && !jump_en && load_use;
  end

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (jump_en) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (state_q == ST_FLUSH) begin
      ifid_flush = 1'b1;
    end
  end

  // STALL never lasts beyond the cycle it is detected in, so it is reported
  // as an overlay on the registered RUN/FLUSH state rather than stored.
  assign ctrl_state = stall ? ST_STALL : state_q;

  always_comb begin
    ex_take_id = id_live && !idex_flush;
    mem_d      = ex_q;
    wb_d       = mem_q;
    ex_d       = '0;
    fwd_rs1_d  = 2'd0;
    fwd_rs2_d  = 2'd0;
    if (ex_take_id) begin
      ex_d.vld  = 1'b1;
      ex_d.rd   = id_rd_addr;
      ex_d.we   = id_rd_we;
      ex_d.load = id_is_load;
      fwd_rs1_d = rs1_ex_hit ? 2'd1 : (rs1_mem_hit ? 2'd2 : 2'd0);
      fwd_rs2_d = rs2_ex_hit ? 2'd1 : (rs2_mem_hit ? 2'd2 : 2'd0);
    end
  end

  // Flush counter holds the number of FLUSH cycles still to come.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (jump_en) begin
      fcnt_d  = FCW'(FLUSH_DEPTH - 1);
      state_d = (FLUSH_DEPTH > 1) ? ST_FLUSH : ST_RUN;
    end else if (state_q == ST_FLUSH) begin
      if (fcnt_q <= FCW'(1)) begin
        fcnt_d  = '0;
        state_d = ST_RUN;
      end else begin
        fcnt_d = fcnt_q - FCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      fcnt_q    <= '0;
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_rs1_q <= 2'd0;
      fwd_rs2_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      fwd_rs1_q <= fwd_rs1_d;
      fwd_rs2_q <= fwd_rs2_d;
    end
  end

  assign fwd_rs1_sel = fwd_rs1_q;
  assign fwd_rs2_sel = fwd_rs2_q;

  // The WB entry is tracked for completeness; the regfile's write-first path covers it.
  assign wb_unused = ^wb_q;

`ifdef RRV_HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
    if (jump_en && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_rrv_hazard_ctrl.sv
// Bench for rrv_hazard_ctrl: directed test-plan sequences plus random traffic,
// all checked against an in-flight-instruction model of the pipeline.
module tb_rrv_hazard_ctrl;
  localparam int RAW = 5;
  localparam int FD  = 2;
  localparam int CW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, jump_en;
  logic [RAW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic           pc_en, ifid_en, ifid_flush, idex_flush;
  logic [1:0]     fwd_rs1_sel, fwd_rs2_sel, ctrl_state;
  logic [CW-1:0]  stall_cnt, flush_cnt;

  rrv_hazard_ctrl #(.REG_ADDR_WIDTH(RAW), .FLUSH_DEPTH(FD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .jump_en(jump_en), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model: the instruction now in EX and the one in MEM, how many FLUSH cycles remain,
  // the selects the EX instruction was issued with, and event tallies.
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } mop_t;

  mop_t   m_ex, m_mem;
  int     m_flush_left, m_sel1, m_sel2;
  longint m_scnt, m_fcnt;

  function automatic bit reads_from(input mop_t p, input bit used, input int addr);
    return used && p.v && p.we && (addr != 0) && (p.rd == addr);
  endfunction

  function automatic int pick_sel(input bit near, input bit far);
    if (near) return 1;
    if (far) return 2;
    return 0;
  endfunction

  task automatic cycle(input bit r, input bit v, input int rs1, input bit u1, input int rs2,
                       input bit u2, input int rd, input bit we, input bit ld, input bit j);
    bit live, h1e, h2e, h1m, h2m, stl, enter;
    bit e_pc, e_en, e_iff, e_idf;
    int e_state;
    longint e_sc, e_fc;
    @(negedge clk);
    rst = r; id_valid = v; jump_en = j;
    id_rs1_addr = RAW'(rs1); id_rs1_used = u1;
    id_rs2_addr = RAW'(rs2); id_rs2_used = u2;
    id_rd_addr = RAW'(rd); id_rd_we = we; id_is_load = ld;
    #1;
    live = v && (m_flush_left == 0);
    h1e  = live && reads_from(m_ex, u1, rs1);
    h2e  = live && reads_from(m_ex, u2, rs2);
    h1m  = live && reads_from(m_mem, u1, rs1);
    h2m  = live && reads_from(m_mem, u2, rs2);
    stl  = !r && !j && m_ex.ld && (h1e || h2e);
    if (r)        begin e_pc = 0; e_en = 0; e_iff = 1; e_idf = 1; end
    else if (j)   begin e_pc = 1; e_en = 1; e_iff = 1; e_idf = 1; end
    else if (stl) begin e_pc = 0; e_en = 0; e_iff = 0; e_idf = 1; end
    else          begin e_pc = 1; e_en = 1; e_iff = (m_flush_left > 0); e_idf = 0; end
    e_state = stl ? 1 : ((m_flush_left > 0) ? 2 : 0);
`ifdef RRV_HAZARD_PERF_EN
    e_sc = m_scnt; e_fc = m_fcnt;
`else
    e_sc = 0; e_fc = 0;
`endif
    check_val("pc_en", pc_en, e_pc);
    check_val("ifid_en", ifid_en, e_en);
    check_val("ifid_flush", ifid_flush, e_iff);
    check_val("idex_flush", idex_flush, e_idf);
    check_val("ctrl_state", ctrl_state, e_state);
    check_val("fwd_rs1_sel", fwd_rs1_sel, m_sel1);
    check_val("fwd_rs2_sel", fwd_rs2_sel, m_sel2);
    check_val("stall_cnt", stall_cnt, e_sc);
    check_val("flush_cnt", flush_cnt, e_fc);
    if (r) begin
      m_ex = '{0, 0, 0, 0}; m_mem = '{0, 0, 0, 0};
      m_flush_left = 0; m_sel1 = 0; m_sel2 = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      m_mem = m_ex;
      enter = live && !j && !stl;
      if (enter) begin
        m_ex = '{1, rd, we, ld};
        m_sel1 = pick_sel(h1e, h1m);
        m_sel2 = pick_sel(h2e, h2m);
      end else begin
        m_ex = '{0, 0, 0, 0}; m_sel1 = 0; m_sel2 = 0;
      end
      if (j) m_flush_left = FD - 1;
      else if (m_flush_left > 0) m_flush_left--;
      if (stl && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      if (j && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
    end
  endtask

  // Shorthands: ALU op, load, bubble.
  task automatic alu(input int rd, input int rs1, input bit u1, input int rs2, input bit u2);
    cycle(0, 1, rs1, u1, rs2, u2, rd, 1, 0, 0);
  endtask
  task automatic load(input int rd, input int rs1);
    cycle(0, 1, rs1, 1, 0, 0, rd, 1, 1, 0);
  endtask
  task automatic bubble(input bit j);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, j);
  endtask

  initial begin
    m_ex = '{0, 0, 0, 0}; m_mem = '{0, 0, 0, 0};
    m_flush_left = 0; m_sel1 = 0; m_sel2 = 0; m_scnt = 0; m_fcnt = 0;
    rst = 1; id_valid = 0; jump_en = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd_we = 0; id_is_load = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("rst_pc_en", pc_en, 0);
    check_val("rst_idex_flush", idex_flush, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // addi x5 ; add x6,x5,x5
    alu(5, 0, 1, 0, 0);
    alu(6, 5, 1, 5, 1);
    check_val("b2b_pc_en", pc_en, 1);
    bubble(0);
    check_val("b2b_rs1", fwd_rs1_sel, 1);
    check_val("b2b_rs2", fwd_rs2_sel, 1);

    // addi x5 ; nop ; sub x7,x5,x1
    alu(5, 0, 1, 0, 0);
    bubble(0);
    alu(7, 5, 1, 1, 1);
    bubble(0);
    check_val("gap_rs1", fwd_rs1_sel, 2);
    check_val("gap_rs2", fwd_rs2_sel, 0);

    // lw x8 ; add x9,x8,x0
    load(8, 2);
    alu(9, 8, 1, 0, 1);
    check_val("lu_pc_en", pc_en, 0);
    check_val("lu_ifid_en", ifid_en, 0);
    check_val("lu_idex_flush", idex_flush, 1);
    check_val("lu_state", ctrl_state, 1);
    alu(9, 8, 1, 0, 1);
    check_val("lu_release_pc_en", pc_en, 1);
    bubble(0);
    check_val("lu_rs1", fwd_rs1_sel, 2);

    // lw x0 ; add x1,x0,x0
    load(0, 3);
    alu(1, 0, 1, 0, 1);
    check_val("x0_pc_en", pc_en, 1);
    check_val("x0_state", ctrl_state, 0);
    bubble(0);
    check_val("x0_rs1", fwd_rs1_sel, 0);
    check_val("x0_rs2", fwd_rs2_sel, 0);

    // Jump in the same cycle as a load-use hazard
    load(8, 2);
    cycle(0, 1, 8, 1, 0, 1, 9, 1, 0, 1);
    check_val("js_pc_en", pc_en, 1);
    check_val("js_ifid_flush", ifid_flush, 1);
    check_val("js_idex_flush", idex_flush, 1);
    bubble(0);
    check_val("js_flush_state", ctrl_state, 2);
    bubble(0);
    check_val("js_run_state", ctrl_state, 0);

    // Reset in the middle of a flush
    load(8, 2);
    bubble(1);
    alu(9, 8, 1, 0, 0);
    check_val("mf_state", ctrl_state, 2);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    alu(9, 8, 1, 8, 1);
    check_val("mf_after_state", ctrl_state, 0);
    check_val("mf_after_pc_en", pc_en, 1);
    check_val("mf_after_ifid_flush", ifid_flush, 0);
    bubble(0);
    check_val("mf_empty_rs1", fwd_rs1_sel, 0);

    // Three load-use stalls and two jumps from a clean reset
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      load(8, 2);
      alu(9, 8, 1, 0, 0);
      alu(9, 8, 1, 0, 0);
      bubble(0);
    end
    for (int k = 0; k < 2; k++) begin
      bubble(1);
      bubble(0);
      bubble(0);
    end
`ifdef RRV_HAZARD_PERF_EN
    check_val("perf_stall_cnt", stall_cnt, 3);
    check_val("perf_flush_cnt", flush_cnt, 2);
`else
    check_val("perf_stall_cnt", stall_cnt, 0);
    check_val("perf_flush_cnt", flush_cnt, 0);
`endif

    // Random traffic over a small register set so hazards are frequent
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1), ($urandom_range(0, 11) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
